// File: rtl/msrv32_mem_pkg.sv
// msrv32_mem_pkg: shared constants, region type and lane-merge helper for the msrv32 memory responder
package msrv32_mem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
    localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
    localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] TMR_MSIP        = 5'h10;

    typedef enum logic [1:0] {REG_DMEM, REG_TMR, REG_NONE} region_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/msrv32_mem_timer.sv
// msrv32_mem_timer: machine timer (mtime/mtimecmp), prescaler and software-IRQ register
module msrv32_mem_timer
    import msrv32_mem_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  offset,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    output logic [31:0] rdata,
    output logic [63:0] mtime,
    output logic        tirq,
    output logic        sirq
);

    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt;
    logic [63:0]   mtimecmp, mtime_d, cmp_d;
    logic          msip, msip_d, tick;

    // written lanes override the incremented value; unwritten lanes keep the increment
    always_comb begin
        tick = cnt == PW'(TICK_DIV - 1);
        mtime_d = mtime + 64'(tick);
        cmp_d = mtimecmp;
        msip_d = msip;
        if (wr_en) begin
            if (offset == TMR_MTIME_LO) mtime_d[31:0] = lane_merge(mtime_d[31:0], wdata, mask);
            if (offset == TMR_MTIME_HI) mtime_d[63:32] = lane_merge(mtime_d[63:32], wdata, mask);
            if (offset == TMR_MTIMECMP_LO) cmp_d[31:0] = lane_merge(cmp_d[31:0], wdata, mask);
            if (offset == TMR_MTIMECMP_HI) cmp_d[63:32] = lane_merge(cmp_d[63:32], wdata, mask);
            if (offset == TMR_MSIP && mask[0]) msip_d = wdata[0];
        end
    end

    assign rdata = offset == TMR_MTIME_LO    ? mtime[31:0] :
                   offset == TMR_MTIME_HI    ? mtime[63:32] :
                   offset == TMR_MTIMECMP_LO ? mtimecmp[31:0] :
                   offset == TMR_MTIMECMP_HI ? mtimecmp[63:32] :
                   offset == TMR_MSIP        ? {31'b0, msip} : '0;

    assign sirq = msip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mtime <= '0;
            mtimecmp <= '1;
            msip <= 1'b0;
            tirq <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            mtime <= mtime_d;
            mtimecmp <= cmp_d;
            msip <= msip_d;
            tirq <= mtime_d >= cmp_d;
        end
    end

endmodule

// File: rtl/msrv32_mem_responder.sv
// msrv32_mem_responder: fixed-latency IMEM, byte-masked DMEM and MMIO timer slave beside the msrv32 core
module msrv32_mem_responder
  import msrv32_mem_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] DMEM_BASE  = 32'h0001_0000,
  parameter logic [31:0] TIMER_BASE = 32'h0002_0000,
  parameter int          TICK_DIV   = 1,
  parameter string       IMEM_INIT  = ""
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_imaddr_in,
  output logic [31:0] ms_riscv32_mp_instr_out,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [63:0] ms_riscv32_mp_rc_out,
  output logic        ms_riscv32_mp_tirq_out,
  output logic        ms_riscv32_mp_sirq_out,
  output logic        ms_riscv32_mp_eirq_out,
  input  logic        ext_irq_in,
  output logic        bus_err_out
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] doff, toff, t_rdata;
  logic [1:0]  sync;
  region_t     rgn;
  logic        t_wr, unused_addr_bits;
  assign doff = ms_riscv32_mp_dmaddr_in - DMEM_BASE;
  assign toff = ms_riscv32_mp_dmaddr_in - TIMER_BASE;
  assign rgn = doff < 32'(4 * DMEM_WORDS) ? REG_DMEM : toff < 32'd32 ? REG_TMR : REG_NONE;
  assign t_wr = ms_riscv32_mp_dmwr_req_in && rgn == REG_TMR;
  assign ms_riscv32_mp_eirq_out = sync[1];
  assign unused_addr_bits = ^ms_riscv32_mp_imaddr_in[1:0];
  msrv32_mem_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk(ms_riscv32_mp_clk_in),
    .rst(ms_riscv32_mp_rst_in),
    .wr_en(t_wr),
    .offset({toff[4:2], 2'b00}),
    .wdata(ms_riscv32_mp_dmdata_in),
    .mask(ms_riscv32_mp_dmwr_mask_in),
    .rdata(t_rdata),
    .mtime(ms_riscv32_mp_rc_out),
    .tirq(ms_riscv32_mp_tirq_out),
    .sirq(ms_riscv32_mp_sirq_out)
  );
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      ms_riscv32_mp_instr_out <= NOP_INSTR;
      ms_riscv32_mp_dmdata_out <= '0;
      bus_err_out <= 1'b0;
      sync <= '0;
    end else begin
      ms_riscv32_mp_instr_out <= ms_riscv32_mp_imaddr_in < 32'(4 * IMEM_WORDS) ?
                                 imem[ms_riscv32_mp_imaddr_in[IW+1:2]] : NOP_INSTR;
      ms_riscv32_mp_dmdata_out <= rgn == REG_DMEM ? dmem[doff[DW+1:2]] :
                                  rgn == REG_TMR  ? t_rdata : '0;
      bus_err_out <= ms_riscv32_mp_dmwr_req_in && rgn == REG_NONE;
      sync <= {sync[0], ext_irq_in};
    end
  end
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in && ms_riscv32_mp_dmwr_req_in && rgn == REG_DMEM)
      for (int i = 0; i < 4; i++)
        if (ms_riscv32_mp_dmwr_mask_in[i])
          dmem[doff[DW+1:2]][8*i +: 8] <= ms_riscv32_mp_dmdata_in[8*i +: 8];
  end
endmodule

// File: tb/tb_msrv32_mem_responder.sv
// tb_msrv32_mem_responder: directed plus randomized checks against a transaction-level memory/timer model
module tb_msrv32_mem_responder;

    localparam int          TICK = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] DB   = 32'h0001_0000;
    localparam logic [31:0] TB   = 32'h0002_0000;

    logic        clk = 0, rst = 1;
    logic [31:0] imaddr = 0, dmaddr = 0, wdata = 0;
    logic        req = 0, ext = 0;
    logic [3:0]  mask = 0;
    logic [31:0] instr, dout;
    logic [63:0] rc;
    logic        tirq, sirq, eirq, err;
    int          vectors = 0, miscompares = 0;

    logic [31:0] imem_m [1024];
    logic [31:0] dmem_m [int];
    logic [63:0] mtime_m, cmp_m;
    logic [31:0] instr_m, dout_m;
    logic        msip_m, tirq_m, err_m, dout_ok;
    logic [1:0]  sync_m;
    int          pre_m;

    always #5 clk = ~clk;

    msrv32_mem_responder #(.TICK_DIV(TICK)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .ms_riscv32_mp_imaddr_in(imaddr),
        .ms_riscv32_mp_instr_out(instr),
        .ms_riscv32_mp_dmaddr_in(dmaddr),
        .ms_riscv32_mp_dmdata_in(wdata),
        .ms_riscv32_mp_dmwr_req_in(req),
        .ms_riscv32_mp_dmwr_mask_in(mask),
        .ms_riscv32_mp_dmdata_out(dout),
        .ms_riscv32_mp_rc_out(rc),
        .ms_riscv32_mp_tirq_out(tirq),
        .ms_riscv32_mp_sirq_out(sirq),
        .ms_riscv32_mp_eirq_out(eirq),
        .ext_irq_in(ext),
        .bus_err_out(err)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = nw[8*i +: 8];
        return old;
    endfunction

    function automatic logic [31:0] tmr_read(input int t);
        case (t)
            0: return mtime_m[31:0];
            1: return mtime_m[63:32];
            2: return cmp_m[31:0];
            3: return cmp_m[63:32];
            4: return {31'b0, msip_m};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        instr_m = NOP; dout_m = 0; dout_ok = 1; err_m = 0;
        mtime_m = 0; cmp_m = '1; msip_m = 0; tirq_m = 0; pre_m = 0; sync_m = 0;
    endtask

    // advance the model by one clock using the inputs now applied, then let the DUT take the edge
    task automatic step();
        bit dhit, thit, tick;
        int w, t;
        logic [63:0] nt;
        dhit = dmaddr >= DB && dmaddr < DB + 32'h1000;
        thit = dmaddr >= TB && dmaddr < TB + 32'd32;
        w = int'((dmaddr - DB) >> 2);
        t = int'((dmaddr - TB) >> 2);
        if (rst) model_reset();
        else begin
            instr_m = imaddr < 32'd4096 ? imem_m[imaddr >> 2] : NOP;
            dout_ok = !dhit || dmem_m.exists(w);
            dout_m = dhit ? (dout_ok ? dmem_m[w] : 32'h0) : thit ? tmr_read(t) : 32'h0;
            err_m = req && !dhit && !thit;
            tick = pre_m == TICK - 1;
            pre_m = (pre_m + 1) % TICK;
            nt = mtime_m + 64'(tick);
            if (req && thit) begin
                if (t == 0) nt[31:0] = merge(nt[31:0], wdata, mask);
                if (t == 1) nt[63:32] = merge(nt[63:32], wdata, mask);
                if (t == 2) cmp_m[31:0] = merge(cmp_m[31:0], wdata, mask);
                if (t == 3) cmp_m[63:32] = merge(cmp_m[63:32], wdata, mask);
                if (t == 4 && mask[0]) msip_m = wdata[0];
            end
            mtime_m = nt;
            tirq_m = mtime_m >= cmp_m;
            if (req && dhit && (dmem_m.exists(w) || mask == 4'hF))
                dmem_m[w] = merge(dmem_m.exists(w) ? dmem_m[w] : 32'h0, wdata, mask);
            sync_m = {sync_m[0], ext};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("instr", 64'(instr), 64'(instr_m));
        if (dout_ok) chk("dmdata", 64'(dout), 64'(dout_m));
        chk("bus_err", 64'(err), 64'(err_m));
        chk("rc", rc, mtime_m);
        chk("tirq", 64'(tirq), 64'(tirq_m));
        chk("sirq", 64'(sirq), 64'(msip_m));
        chk("eirq", 64'(eirq), 64'(sync_m[1]));
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic r, input logic [3:0] m);
        dmaddr = a; wdata = d; req = r; mask = m;
        step();
        check_all();
    endtask

    initial begin
        logic [31:0] v;
        logic [63:0] prev;
        int t9, period, r;
        bit found;
        for (int k = 0; k < 1024; k++) begin
            imem_m[k] = $urandom;
            dut.imem[k] = imem_m[k];
        end
        model_reset();
        imaddr = 32'h0000_8000;
        op(DB, 0, 0, 0);
        op(DB, 0, 0, 0);
        chk("rst_instr", 64'(instr), 64'(NOP));
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_rc", rc, 64'h0);
        chk("rst_irqs", 64'({tirq, sirq, eirq, err}), 64'h0);
        rst = 0;

        op(DB, 32'hAABBCCDD, 1, 4'hF);
        op(DB, 32'h11223344, 1, 4'b0100);
        chk("same_cycle_old", 64'(dout), 64'hAABBCCDD);
        op(DB, 0, 0, 0);
        chk("mask_merge", 64'(dout), 64'hAA22CCDD);
        for (int k = 1; k < 16; k++) op(DB + 32'(4 * k), $urandom, 1, 4'hF);

        op(32'h0003_0000, 32'hDEADBEEF, 1, 4'hF);
        chk("err_pulse", 64'(err), 64'h1);
        op(32'h0003_0000, 0, 0, 0);
        chk("err_clear", 64'(err), 64'h0);
        chk("miss_load", 64'(dout), 64'h0);
        op(DB, 0, 0, 0);
        chk("miss_no_write", 64'(dout), 64'hAA22CCDD);

        op(TB + 32'h0, 0, 1, 4'hF);
        op(TB + 32'hC, 0, 1, 4'hF);
        op(TB + 32'h8, 32'd10, 1, 4'hF);
        prev = rc; t9 = -100; period = 0; found = 0;
        for (int i = 0; i < 120 && !found; i++) begin
            op(DB, 0, 0, 0);
            if (rc == 64'd9 && prev != 64'd9) begin
                t9 = i;
                chk("tirq_below_cmp", 64'(tirq), 64'h0);
            end
            if (rc == 64'd10) begin
                found = 1;
                period = i - t9;
            end
            prev = rc;
        end
        chk("mtime_reaches_10", 64'(found), 64'h1);
        chk("tick_period", 64'(period), 64'(TICK));
        chk("tirq_at_cmp", 64'(tirq), 64'h1);
        op(TB + 32'hC, 32'd1, 1, 4'hF);
        chk("tirq_fall", 64'(tirq), 64'h0);

        op(TB + 32'h4, 32'hFFFF_FFFF, 1, 4'hF);
        op(TB + 32'h0, 32'hFFFF_FFFF, 1, 4'hF);
        chk("mtime_preload", rc, 64'hFFFF_FFFF_FFFF_FFFF);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            op(DB, 0, 0, 0);
            if (rc == 64'h0) found = 1;
        end
        chk("mtime_wrap", 64'(found), 64'h1);

        for (int i = 0; i < TICK && pre_m != 1; i++) op(DB, 0, 0, 0);
        op(TB + 32'h4, 32'd5, 1, 4'hF);
        op(TB + 32'h0, 32'hFFFF_FFFF, 1, 4'hF);
        op(TB + 32'h0, 32'h1234_5678, 1, 4'hF);
        chk("write_beats_tick", rc, 64'h0000_0006_1234_5678);

        op(TB + 32'h10, 32'hFFFF_FFFF, 1, 4'hF);
        op(TB + 32'h10, 0, 0, 0);
        chk("msip_read", 64'(dout), 64'h1);
        chk("msip_sirq", 64'(sirq), 64'h1);
        op(TB + 32'h14, 32'hFFFF_FFFF, 1, 4'hF);
        op(TB + 32'h14, 0, 0, 0);
        chk("reserved_read", 64'(dout), 64'h0);

        ext = 1;
        op(DB, 0, 0, 0);
        chk("eirq_after_1", 64'(eirq), 64'h0);
        op(DB, 0, 0, 0);
        chk("eirq_after_2", 64'(eirq), 64'h1);
        ext = 0;
        op(DB, 0, 0, 0);
        op(DB, 0, 0, 0);
        chk("eirq_clear", 64'(eirq), 64'h0);

        foreach (imem_m[k]) if (k == 0 || k == 1 || k == 77 || k == 1023) begin
            imaddr = 32'(4 * k) | 32'($urandom_range(0, 3));
            op(DB, 0, 0, 0);
            chk("fetch_word", 64'(instr), 64'(imem_m[k]));
        end
        imaddr = 32'd4096;
        op(DB, 0, 0, 0);
        chk("fetch_beyond", 64'(instr), 64'(NOP));

        v = dmem_m[1];
        dmaddr = DB + 32'h4; wdata = 32'h5555_AAAA; req = 1; mask = 4'hF;
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        chk("async_rst_dout", 64'(dout), 64'h0);
        chk("async_rst_rc", rc, 64'h0);
        step();
        check_all();
        rst = 0;
        op(DB + 32'h4, 0, 0, 0);
        chk("rst_store_dropped", 64'(dout), 64'(v));

        for (int i = 0; i < 400; i++) begin
            imaddr = $urandom_range(0, 4200);
            ext = 1'($urandom);
            r = int'($urandom_range(0, 9));
            op(r < 6 ? DB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)) :
               r < 9 ? TB + 32'($urandom_range(0, 31)) : 32'h0004_0000 + 32'($urandom_range(0, 1023)),
               $urandom, 1'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
